// File: rtl/ascon_job_arbiter_pkg.sv
// Shared types and constants for the ASCON job arbiter: FSM states,
// datapath widths and the block-length clamp.
package ascon_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      FEED,
      WAIT_CT,
      WAIT_TAG
   } arb_state_e;

   localparam int ASCON_BLK_BITS = 64;
   localparam int ASCON_KEY_BITS = 128;
   localparam int ASCON_TAG_BITS = 128;
   localparam int ASCON_MAX_LEN  = 8;

   // Lengths above a full block are treated as a full block.
   function automatic logic [3:0] clamp_len(input logic [3:0] len);
      return (len > 4'(ASCON_MAX_LEN)) ? 4'(ASCON_MAX_LEN) : len;
   endfunction

endpackage

// File: rtl/ascon_job_arbiter_if.sv
// Requester, core and result signals of the ASCON job arbiter.
// The arbiter connects through the slave modport.
interface ascon_job_arbiter_if
   import ascon_arb_pkg::*;
#(
   parameter int NREQ = 2
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]                req_valid;
   logic [NREQ-1:0]                req_ready;
   logic [2*NREQ-1:0]              req_mode;
   logic [ASCON_KEY_BITS*NREQ-1:0] req_key;
   logic [ASCON_KEY_BITS*NREQ-1:0] req_nonce;
   logic [NREQ-1:0]                blk_valid;
   logic [NREQ-1:0]                blk_ready;
   logic [ASCON_BLK_BITS*NREQ-1:0] blk_data;
   logic [4*NREQ-1:0]              blk_len;
   logic [NREQ-1:0]                blk_last;
   logic                           core_start;
   logic [1:0]                     core_mode;
   logic [ASCON_KEY_BITS-1:0]      core_key;
   logic [ASCON_KEY_BITS-1:0]      core_nonce;
   logic [ASCON_BLK_BITS-1:0]      core_blockin;
   logic [3:0]                     core_datalen;
   logic [ASCON_BLK_BITS-1:0]      core_ctblock;
   logic                           core_ctv;
   logic [ASCON_TAG_BITS-1:0]      core_tag;
   logic                           core_tv;
   logic [ASCON_BLK_BITS-1:0]      ct_data;
   logic                           ct_valid;
   logic [IDW-1:0]                 ct_id;
   logic [ASCON_TAG_BITS-1:0]      tag;
   logic                           tag_valid;
   logic [IDW-1:0]                 tag_id;
   logic                           err;
   logic [IDW-1:0]                 err_id;
   logic                           busy;
   logic [NREQ-1:0]                grant;

   modport slave (
      input  req_valid, req_mode, req_key, req_nonce,
      input  blk_valid, blk_data, blk_len, blk_last,
      input  core_ctblock, core_ctv, core_tag, core_tv,
      output req_ready, blk_ready,
      output core_start, core_mode, core_key, core_nonce, core_blockin, core_datalen,
      output ct_data, ct_valid, ct_id, tag, tag_valid, tag_id, err, err_id, busy, grant
   );

   modport master (
      output req_valid, req_mode, req_key, req_nonce,
      output blk_valid, blk_data, blk_len, blk_last,
      output core_ctblock, core_ctv, core_tag, core_tv,
      input  req_ready, blk_ready,
      input  core_start, core_mode, core_key, core_nonce, core_blockin, core_datalen,
      input  ct_data, ct_valid, ct_id, tag, tag_valid, tag_id, err, err_id, busy, grant
   );

endinterface

// File: rtl/ascon_job_arbiter_rr_pick.sv
// Round-robin pick: first asserted request scanning upward from rr_ptr+1
// with wrap-around.
module ascon_rr_pick #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   output logic            found,
   output logic [IDW-1:0]  id
);

   int unsigned idx;

   always_comb begin
      found = 1'b0;
      id    = '0;
      idx   = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(rr_ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            id    = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/ascon_job_arbiter.sv
// Shares one ASCON AEAD core between NREQ requesters, one whole job at a
// time, with round-robin fairness and a watchdog on a silent core.
module ascon_job_arbiter
   import ascon_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                nRST,
   ascon_job_arbiter_if.slave  arb
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   arb_state_e                state, state_n;
   logic [IDW-1:0]            rr_ptr, id_q, pick_id;
   logic [TW-1:0]             timer;
   logic                      found, waiting, last_q;
   logic                      accept, take, ct_fire, tag_fire, timeout, done;
   logic [1:0]                mode_q;
   logic [ASCON_KEY_BITS-1:0] key_q, nonce_q;
   logic [ASCON_BLK_BITS-1:0] blockin_q, ct_data_q;
   logic [3:0]                datalen_q;
   logic [ASCON_TAG_BITS-1:0] tag_q;
   logic [NREQ-1:0]           req_ready_q, owner;
   logic                      core_start_q, ct_valid_q, tag_valid_q, err_q;
   logic [IDW-1:0]            ct_id_q, tag_id_q, err_id_q;

   ascon_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req    (arb.req_valid),
      .rr_ptr (rr_ptr),
      .found  (found),
      .id     (pick_id)
   );

   assign waiting = (state == WAIT_CT) || (state == WAIT_TAG);
   assign owner   = NREQ'(1) << id_q;

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      take     = 1'b0;
      ct_fire  = 1'b0;
      tag_fire = 1'b0;
      timeout  = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (found) begin
            accept  = 1'b1;
            state_n = START;
         end
         START: state_n = FEED;
         FEED: if (arb.blk_valid[id_q]) begin
            take    = 1'b1;
            state_n = WAIT_CT;
         end
         // A core event always beats a watchdog expiry in the same cycle.
         WAIT_CT: begin
            if (arb.core_ctv) begin
               ct_fire = 1'b1;
               if (!last_q) state_n = FEED;
               else if (arb.core_tv) begin
                  tag_fire = 1'b1;
                  done     = 1'b1;
                  state_n  = IDLE;
               end else state_n = WAIT_TAG;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_n = IDLE;
            end
         end
         WAIT_TAG: begin
            if (arb.core_tv) begin
               tag_fire = 1'b1;
               done     = 1'b1;
               state_n  = IDLE;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state        <= IDLE;
         rr_ptr       <= IDW'(NREQ - 1);
         timer        <= '0;
         id_q         <= '0;
         mode_q       <= '0;
         key_q        <= '0;
         nonce_q      <= '0;
         blockin_q    <= '0;
         datalen_q    <= '0;
         last_q       <= 1'b0;
         req_ready_q  <= '0;
         core_start_q <= 1'b0;
         ct_data_q    <= '0;
         ct_valid_q   <= 1'b0;
         ct_id_q      <= '0;
         tag_q        <= '0;
         tag_valid_q  <= 1'b0;
         tag_id_q     <= '0;
         err_q        <= 1'b0;
         err_id_q     <= '0;
      end else begin
         state        <= state_n;
         // Timer restarts on every state change, so each wait state gets a full budget.
         timer        <= (waiting && state_n == state) ? timer + 1'b1 : '0;
         req_ready_q  <= accept ? (NREQ'(1) << pick_id) : '0;
         core_start_q <= (state == START);
         ct_valid_q   <= ct_fire;
         tag_valid_q  <= tag_fire;
         err_q        <= timeout;
         if (accept) begin
            id_q    <= pick_id;
            mode_q  <= arb.req_mode[2*pick_id +: 2];
            key_q   <= arb.req_key[ASCON_KEY_BITS*pick_id +: ASCON_KEY_BITS];
            nonce_q <= arb.req_nonce[ASCON_KEY_BITS*pick_id +: ASCON_KEY_BITS];
         end
         if (take) begin
            blockin_q <= arb.blk_data[ASCON_BLK_BITS*id_q +: ASCON_BLK_BITS];
            datalen_q <= clamp_len(arb.blk_len[4*id_q +: 4]);
            last_q    <= arb.blk_last[id_q];
         end
         if (ct_fire) begin
            ct_data_q <= arb.core_ctblock;
            ct_id_q   <= id_q;
         end
         if (tag_fire) begin
            tag_q    <= arb.core_tag;
            tag_id_q <= id_q;
         end
         if (timeout) err_id_q <= id_q;
         if (done || timeout) rr_ptr <= id_q;
      end
   end

   assign arb.req_ready    = req_ready_q;
   assign arb.blk_ready    = (state == FEED) ? owner : '0;
   assign arb.core_start   = core_start_q;
   assign arb.core_mode    = mode_q;
   assign arb.core_key     = key_q;
   assign arb.core_nonce   = nonce_q;
   assign arb.core_blockin = blockin_q;
   assign arb.core_datalen = datalen_q;
   assign arb.ct_data      = ct_data_q;
   assign arb.ct_valid     = ct_valid_q;
   assign arb.ct_id        = ct_id_q;
   assign arb.tag          = tag_q;
   assign arb.tag_valid    = tag_valid_q;
   assign arb.tag_id       = tag_id_q;
   assign arb.err          = err_q;
   assign arb.err_id       = err_id_q;
   assign arb.busy         = (state != IDLE);
   assign arb.grant        = (state != IDLE) ? owner : '0;

endmodule

// File: tb/tb_ascon_job_arbiter.sv
// Bench for ascon_job_arbiter: the bench plays both requesters and the core,
// queuing every result it expects and matching them as the DUT emits them.
module tb_ascon_job_arbiter;
   import ascon_arb_pkg::*;

   localparam int NREQ = 2;
   localparam int TMO  = 8;

   logic clk  = 1'b0;
   logic nRST = 1'b0;

   ascon_job_arbiter_if #(.NREQ(NREQ)) arb ();

   ascon_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
      .clk  (clk),
      .nRST (nRST),
      .arb  (arb.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           kind;   // 0 ciphertext, 1 tag, 2 timeout
      int           id;
      logic [127:0] data;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_pass   = 0;
   int           rr_m     = NREQ - 1;
   logic [127:0] keys[NREQ];
   logic [127:0] nonces[NREQ];
   logic [1:0]   modes[NREQ];

   task automatic check_eq(input string nm, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, want);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic int pick(input logic [1:0] r);
      for (int k = 1; k <= NREQ; k++) begin
         int idx = (rr_m + k) % NREQ;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic pop_check(input int kind, input int id, input logic [127:0] data, input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         check_eq({nm, "_unexpected"}, 128'(1), 128'(0));
         return;
      end
      e = sb.pop_front();
      check_eq({nm, "_kind"}, 128'(kind), 128'(e.kind));
      check_eq({nm, "_id"}, 128'(id), 128'(e.id));
      check_eq({nm, "_data"}, data, e.data);
   endtask

   // Output monitor: every valid pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (arb.ct_valid)  pop_check(0, int'(arb.ct_id), 128'(arb.ct_data), "ct");
      if (arb.tag_valid) pop_check(1, int'(arb.tag_id), arb.tag, "tag");
      if (arb.err)       pop_check(2, int'(arb.err_id), 128'(0), "err");
   end

   task automatic check_all_zero(input string p);
      check_eq({p, "_req_ready"}, 128'(arb.req_ready), 128'(0));
      check_eq({p, "_blk_ready"}, 128'(arb.blk_ready), 128'(0));
      check_eq({p, "_core_start"}, 128'(arb.core_start), 128'(0));
      check_eq({p, "_core_mode"}, 128'(arb.core_mode), 128'(0));
      check_eq({p, "_core_key"}, arb.core_key, 128'(0));
      check_eq({p, "_core_nonce"}, arb.core_nonce, 128'(0));
      check_eq({p, "_core_blockin"}, 128'(arb.core_blockin), 128'(0));
      check_eq({p, "_core_datalen"}, 128'(arb.core_datalen), 128'(0));
      check_eq({p, "_ct_data"}, 128'(arb.ct_data), 128'(0));
      check_eq({p, "_ct_valid"}, 128'(arb.ct_valid), 128'(0));
      check_eq({p, "_ct_id"}, 128'(arb.ct_id), 128'(0));
      check_eq({p, "_tag"}, arb.tag, 128'(0));
      check_eq({p, "_tag_valid"}, 128'(arb.tag_valid), 128'(0));
      check_eq({p, "_tag_id"}, 128'(arb.tag_id), 128'(0));
      check_eq({p, "_err"}, 128'(arb.err), 128'(0));
      check_eq({p, "_err_id"}, 128'(arb.err_id), 128'(0));
      check_eq({p, "_busy"}, 128'(arb.busy), 128'(0));
      check_eq({p, "_grant"}, 128'(arb.grant), 128'(0));
   endtask

   // mode: 0 normal, 1 ctv+tv together on last block, 2 silent core, 3 reset in WAIT_TAG
   task automatic run_job(input logic [1:0] reqs, input bit hold, input int nblk,
                          input logic [3:0] len_last, input int mode);
      int          id, other;
      bit          got;
      bit          last;
      logic [63:0] d, ctb;
      logic [3:0]  len;
      logic [127:0] tg;
      exp_t        e;
      id    = pick(reqs);
      other = 1 - id;
      arb.req_valid = reqs;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
         tick();
         if (arb.req_ready != '0) got = 1'b1;
      end
      if (!got) begin
         check_eq("req_accept_timeout", 128'(0), 128'(1));
         arb.req_valid = '0;
         return;
      end
      check_eq("req_ready", 128'(arb.req_ready), 128'(2'b01 << id));
      check_eq("core_start_early", 128'(arb.core_start), 128'(0));
      if (!hold) arb.req_valid = '0;
      tick();
      check_eq("core_start", 128'(arb.core_start), 128'(1));
      check_eq("grant", 128'(arb.grant), 128'(2'b01 << id));
      check_eq("core_mode", 128'(arb.core_mode), 128'(modes[id]));
      check_eq("core_key", arb.core_key, keys[id]);
      check_eq("core_nonce", arb.core_nonce, nonces[id]);
      for (int b = 0; b < nblk; b++) begin
         last = (b == nblk - 1);
         len  = last ? len_last : 4'd8;
         d    = {$urandom, $urandom};
         check_eq("blk_ready_feed", 128'(arb.blk_ready), 128'(2'b01 << id));
         arb.blk_valid[id]            = 1'b1;
         arb.blk_data[64*id +: 64]    = d;
         arb.blk_len[4*id +: 4]       = len;
         arb.blk_last[id]             = last;
         arb.blk_valid[other]         = 1'b1;
         arb.blk_data[64*other +: 64] = ~d;
         arb.blk_len[4*other +: 4]    = 4'd1;
         tick();
         arb.blk_valid = '0;
         arb.blk_last  = '0;
         check_eq("core_blockin", 128'(arb.core_blockin), 128'(d));
         check_eq("core_datalen", 128'(arb.core_datalen), 128'((len > 4'd8) ? 4'd8 : len));
         check_eq("blk_ready_wait", 128'(arb.blk_ready), 128'(0));
         if (mode == 2) begin
            e.kind = 2; e.id = id; e.data = '0;
            sb.push_back(e);
            for (int c = 1; c < TMO; c++) begin
               tick();
               check_eq("err_early", 128'(arb.err), 128'(0));
            end
            tick();
            check_eq("err_pulse", 128'(arb.err), 128'(1));
            check_eq("err_idle", 128'(arb.busy), 128'(0));
            rr_m = id;
            return;
         end
         tick();
         tick();
         ctb = d ^ 64'hC3A5_5A3C_0F1E_E1F0;
         arb.core_ctblock = ctb;
         arb.core_ctv     = 1'b1;
         e.kind = 0; e.id = id; e.data = 128'(ctb);
         sb.push_back(e);
         tg = {keys[id][127:64] ^ d, nonces[id][63:0]};
         if (last && mode == 1) begin
            arb.core_tv  = 1'b1;
            arb.core_tag = tg;
            e.kind = 1; e.id = id; e.data = tg;
            sb.push_back(e);
         end
         tick();
         arb.core_ctv = 1'b0;
         arb.core_tv  = 1'b0;
         check_eq("ct_valid", 128'(arb.ct_valid), 128'(1));
         if (last && mode == 1) begin
            check_eq("same_cycle_tag", 128'(arb.tag_valid), 128'(1));
            check_eq("same_cycle_idle", 128'(arb.busy), 128'(0));
            rr_m = id;
            return;
         end
         if (last) begin
            check_eq("wait_tag_busy", 128'(arb.busy), 128'(1));
            if (mode == 3) begin
               tick();
               nRST        = 1'b0;
               arb.core_tv = 1'b1;
               arb.core_tag = tg;
               tick();
               check_all_zero("midjob_rst");
               nRST        = 1'b1;
               arb.core_tv = 1'b0;
               arb.req_valid = '0;
               tick();
               check_eq("rst_no_tag", 128'(arb.tag_valid), 128'(0));
               check_eq("rst_no_err", 128'(arb.err), 128'(0));
               rr_m = NREQ - 1;
               return;
            end
            tick();
            tick();
            tick();
            arb.core_tv  = 1'b1;
            arb.core_tag = tg;
            e.kind = 1; e.id = id; e.data = tg;
            sb.push_back(e);
            tick();
            arb.core_tv = 1'b0;
            check_eq("tag_valid", 128'(arb.tag_valid), 128'(1));
            check_eq("busy_after_tag", 128'(arb.busy), 128'(0));
            check_eq("grant_after_tag", 128'(arb.grant), 128'(0));
            rr_m = id;
         end
      end
   endtask

   initial begin
      arb.req_valid    = '0;
      arb.blk_valid    = '0;
      arb.blk_data     = '0;
      arb.blk_len      = '0;
      arb.blk_last     = '0;
      arb.core_ctblock = '0;
      arb.core_ctv     = 1'b0;
      arb.core_tag     = '0;
      arb.core_tv      = 1'b0;
      modes[0] = 2'b01;
      modes[1] = 2'b10;
      for (int i = 0; i < NREQ; i++) begin
         keys[i]   = {$urandom, $urandom, $urandom, $urandom};
         nonces[i] = {$urandom, $urandom, $urandom, $urandom};
         arb.req_key[128*i +: 128]   = keys[i];
         arb.req_nonce[128*i +: 128] = nonces[i];
         arb.req_mode[2*i +: 2]      = modes[i];
      end
      repeat (3) tick();
      check_all_zero("reset");
      nRST = 1'b1;
      tick();

      // Both requesters held: grants alternate 0,1,0,1.
      for (int j = 0; j < 4; j++) run_job(2'b11, 1'b1, 1, 4'(1 + j), 0);
      arb.req_valid = '0;
      tick();

      run_job(2'b01, 1'b0, 3, 4'd5, 0);
      run_job(2'b10, 1'b0, 2, 4'd3, 1);
      run_job(2'b01, 1'b0, 1, 4'hF, 0);

      // Silent core times out, then the other pending requester is served.
      run_job(2'b11, 1'b1, 1, 4'd8, 2);
      run_job(2'b11, 1'b0, 1, 4'd6, 0);

      run_job(2'b11, 1'b0, 2, 4'd7, 3);
      run_job(2'b11, 1'b0, 1, 4'd8, 0);

      repeat (3) tick();
      check_eq("scoreboard_empty", 128'(sb.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
